tour_cmd_seq: RTL and testbench
===============================

# tour_cmd_seq

Tour command sequencer between the UART command path and `cmd_proc`. On `start_tour` it walks a stored list of knight moves and issues each as two move commands to `cmd_proc`: vertical leg first, then horizontal leg. Each leg waits for `cmd_proc` to acknowledge before the next is issued. While idle it passes UART commands through to `cmd_proc` unchanged, so `cmd_proc` sees exactly one command source at any time.

## Interface
- `NUM_MOVES`, 24: moves per tour (range 1..2^MV_AW).
- `MV_AW`, 5: move-memory address width.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_tour` in 1: single-cycle pulse that begins a tour; ignored while a tour is active.
- `mv_indx` out MV_AW: move-memory read address.
- `move` in 8: one-hot move read from memory, valid one clock after `mv_indx` changes.
- `cmd_UART` in 16: command from the UART wrapper.
- `cmd_rdy_UART` in 1: the UART command is valid.
- `clr_cmd_rdy_UART` out 1: consume the UART command.
- `cmd` out 16: command to `cmd_proc`.
- `cmd_rdy` out 1: `cmd` is valid.
- `clr_cmd_rdy` in 1: `cmd_proc` has taken `cmd`.
- `send_resp` in 1: `cmd_proc` has finished the command (single-cycle pulse).
- `resp` out 8: response byte to the UART.
- `tour_active` out 1: the sequencer owns `cmd_proc`.
- `tour_err` out 1: sticky flag for an illegal move encoding.

## Operation
- **Command format.** `{opcode[3:0], heading[7:0], squares[3:0]}`.
  - Opcode 4'h4 is a move; 4'h5 is a move with fanfare.
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- **Move decode (one-hot bit: vertical leg then horizontal leg).**
  - bit0: N2 then E1. bit1: N2 then W1.
  - bit2: N1 then W2. bit3: S1 then W2.
  - bit4: S2 then W1. bit5: S2 then E1.
  - bit6: S1 then E2. bit7: N1 then E2.
- **Final leg.** The horizontal leg of move `NUM_MOVES-1` uses opcode 4'h5. Every other leg uses 4'h4.
- **States and transitions.**
  - IDLE: on `start_tour`, clear `mv_indx` and `tour_err`, go to FETCH.
  - FETCH: wait one cycle for `move`. If `move` is not one-hot (including 8'h00), set `tour_err` and go to IDLE. Otherwise latch the decode and go to VERT.
  - VERT: drive the vertical command with `cmd_rdy`=1. On `clr_cmd_rdy`, go to VERT_W.
  - VERT_W: on `send_resp`, go to HORZ.
  - HORZ: as VERT, using the horizontal command.
  - HORZ_W: on `send_resp`, either increment `mv_indx` and go to FETCH, or go to IDLE if `mv_indx`==NUM_MOVES-1.
- **Mux.**
  - In IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`.
  - In any other state: `clr_cmd_rdy_UART`=0. UART commands stay pending and are not lost.
- **Response.**
  - `resp`=8'hA5 in IDLE, and on the final leg's `send_resp`.
  - `resp`=8'h5A for every intermediate leg's `send_resp`.
- `tour_active` is 1 in every state except IDLE.

## Timing
- **Reset values.** State IDLE; `mv_indx`=0; `cmd_rdy`=0 (assuming `cmd_rdy_UART`=0); `clr_cmd_rdy_UART`=0; `resp`=8'hA5; `tour_active`=0; `tour_err`=0.
- **Start latency.** `start_tour` at edge N gives `tour_active`=1 after edge N, and the first `cmd_rdy` after edge N+2.
- **Issuing a leg.** `cmd` and `cmd_rdy` are registered and stable from assertion until the edge that samples `clr_cmd_rdy`. `cmd_rdy` drops on the next edge.
- **Early response.** `send_resp` in the same cycle as `clr_cmd_rdy` is held until the W state and then honoured, not dropped.
- **Between moves.** From the last leg's `send_resp` to the next move's `cmd_rdy` is 2 cycles (FETCH, then VERT).
- **Index.** `mv_indx` never exceeds NUM_MOVES-1 and does not wrap.
- **Ignored inputs.**
  - `start_tour` while active: no effect.
  - `clr_cmd_rdy` or `send_resp` in IDLE or FETCH: no state effect.
- **Reset mid-tour.** Immediate return to IDLE with all reset values. The in-flight `cmd_proc` command is abandoned.
- **Error.** `tour_err` rises the cycle after the bad FETCH and holds until the next accepted `start_tour` or `rst`.

## Test plan
- **Pass-through.** IDLE, `cmd_UART`=16'h47F2, `cmd_rdy_UART`=1 → `cmd`=16'h47F2, `cmd_rdy`=1. Then `clr_cmd_rdy` pulse → `clr_cmd_rdy_UART` pulses in the same cycle.
- **Single move.** NUM_MOVES=1, `move`=8'h20.
  - Sequence: `cmd`=16'h47F2, ack, `send_resp` (`resp`=8'h5A), then `cmd`=16'h5BF1, `send_resp` (`resp`=8'hA5).
  - End state: IDLE, `tour_active`=0.
- **Four-move tour.** Moves 8'h20, 8'h01, 8'h02, 8'h10.
  - Issued `cmd` sequence: 16'h47F2, 16'h4BF1, 16'h4002, 16'h4BF1, 16'h4002, 16'h43F1, 16'h47F2, 16'h53F1.
  - Exactly 8 `send_resp`s; `mv_indx` ends at 3.
- **Illegal move.** Move 1 = 8'h03 → `tour_err`=1, IDLE, no third command issued. A pending `cmd_rdy_UART` is then passed through.
- **Contention.** `cmd_rdy_UART`=1 and `start_tour` while active → `clr_cmd_rdy_UART` stays 0 and the second `start_tour` is ignored. After the tour ends, the UART command is forwarded.
- **Reset mid-tour.** `rst` during VERT_W → all reset values on the same cycle, and no `cmd_rdy` after release.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq
//
// Sequences a stored knight's tour into cmd_proc. On start_tour it reads one
// move at a time from the move memory, splits it into a vertical leg and a
// horizontal leg, and issues each leg as a move command, waiting for cmd_proc
// to take and complete one leg before the next. While idle, UART commands pass
// straight through, so cmd_proc only ever sees one command source.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start_tour        one-cycle pulse that starts a tour (ignored while active)
//   mv_indx           move-memory read address
//   move              one-hot move, valid one clock after mv_indx changes
//   cmd_UART          UART command; cmd_rdy_UART marks it valid
//   clr_cmd_rdy_UART  consumes the UART command (only while idle)
//   cmd, cmd_rdy      command to cmd_proc and its valid flag
//   clr_cmd_rdy       cmd_proc has taken cmd
//   send_resp         cmd_proc has finished the command (one-cycle pulse)
//   resp              response byte: 8'hA5 idle or tour complete, 8'h5A per leg
//   tour_active       the sequencer owns cmd_proc
//   tour_err          sticky: an illegal move encoding was read
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24,
  parameter int MV_AW     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  output logic [MV_AW-1:0] mv_indx,
  input  logic [7:0]       move,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_active,
  output logic             tour_err
);

  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h5;

  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_LEG  = 8'h5A;

  localparam logic [MV_AW-1:0] LAST_IDX = MV_AW'(NUM_MOVES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, VERT, VERT_W, HORZ, HORZ_W} state_t;

  state_t state, state_nxt;

  logic [15:0] vert_cmd, horz_cmd;
  logic        fetch_wait, fetch_wait_nxt;
  logic        resp_pend, resp_pend_nxt;
  logic        clr_idx, inc_idx, set_err, latch_legs;
  logic [23:0] legs;
  logic        move_ok;
  logic        is_last;

  // Returns {vertical heading, squares, horizontal heading, squares}.
  function automatic logic [23:0] decode_move(input logic [7:0] mv);
    case (mv)
      8'h01:   decode_move = {HD_N, 4'd2, HD_E, 4'd1};
      8'h02:   decode_move = {HD_N, 4'd2, HD_W, 4'd1};
      8'h04:   decode_move = {HD_N, 4'd1, HD_W, 4'd2};
      8'h08:   decode_move = {HD_S, 4'd1, HD_W, 4'd2};
      8'h10:   decode_move = {HD_S, 4'd2, HD_W, 4'd1};
      8'h20:   decode_move = {HD_S, 4'd2, HD_E, 4'd1};
      8'h40:   decode_move = {HD_S, 4'd1, HD_E, 4'd2};
      8'h80:   decode_move = {HD_N, 4'd1, HD_E, 4'd2};
      default: decode_move = '0;
    endcase
  endfunction

  assign legs    = decode_move(move);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign move_ok = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign is_last = (mv_indx == LAST_IDX);

  // NOTE: every register, including the latched leg commands, is reset so that
  // reset mid-tour leaves no stale command that could reappear on cmd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      state      <= IDLE;
      mv_indx    <= '0;
      vert_cmd   <= '0;
      horz_cmd   <= '0;
      fetch_wait <= 1'b0;
      resp_pend  <= 1'b0;
      tour_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_wait <= fetch_wait_nxt;
      resp_pend  <= resp_pend_nxt;
      if (clr_idx)      mv_indx <= '0;
      else if (inc_idx) mv_indx <= mv_indx + 1'b1;
      if (clr_idx)      tour_err <= 1'b0;
      else if (set_err) tour_err <= 1'b1;
      if (latch_legs) begin
        vert_cmd <= {OP_MOVE, legs[23:12]};
        horz_cmd <= {(is_last ? OP_FANFARE : OP_MOVE), legs[11:0]};
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    fetch_wait_nxt = 1'b0;
    resp_pend_nxt  = resp_pend;
    clr_idx        = 1'b0;
    inc_idx        = 1'b0;
    set_err        = 1'b0;
    latch_legs     = 1'b0;
    case (state)
      IDLE: begin
        if (start_tour) begin
          clr_idx        = 1'b1;
          fetch_wait_nxt = 1'b1;
          state_nxt      = FETCH;
        end
      end
      FETCH: begin
        // First FETCH cycle covers the memory read latency after mv_indx moved.
        if (!fetch_wait) begin
          if (!move_ok) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            latch_legs = 1'b1;
            state_nxt  = VERT;
          end
        end
      end
      VERT, HORZ: begin
        if (clr_cmd_rdy) begin
          // A completion arriving with the ack is remembered for the W state.
          resp_pend_nxt = send_resp;
          state_nxt     = (state == VERT) ? VERT_W : HORZ_W;
        end
      end
      VERT_W: begin
        if (send_resp || resp_pend) begin
          resp_pend_nxt = 1'b0;
          state_nxt     = HORZ;
        end
      end
      HORZ_W: begin
        if (send_resp || resp_pend) begin
          resp_pend_nxt = 1'b0;
          if (is_last) begin
            state_nxt = IDLE;
          end else begin
            inc_idx        = 1'b1;
            fetch_wait_nxt = 1'b1;
            state_nxt      = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tour_active      = (state != IDLE);
  assign clr_cmd_rdy_UART = (state == IDLE) && clr_cmd_rdy;

  always_comb begin
    if (state == IDLE) begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
    end else begin
      cmd     = (state == HORZ || state == HORZ_W) ? horz_cmd : vert_cmd;
      cmd_rdy = (state == VERT || state == HORZ);
    end
  end

  // The final horizontal leg reports tour completion instead of a leg ack.
  always_comb begin
    if (state == IDLE)                                  resp = RESP_DONE;
    else if ((state == HORZ || state == HORZ_W) && is_last) resp = RESP_DONE;
    else                                                resp = RESP_LEG;
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq. Main instance uses NUM_MOVES=4; a second instance
// with NUM_MOVES=1 covers the single-move tour. Expected commands come from a
// displacement table of knight moves (dy, dx) turned into heading/squares.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_tour = 1'b0;
  logic [4:0]  mv_indx;
  logic [7:0]  move;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;
  logic        tour_active;
  logic        tour_err;

  logic        s_start = 1'b0;
  logic [4:0]  s_mv_indx;
  logic [7:0]  s_move;
  logic [15:0] s_cmd_uart = 16'h0000;
  logic        s_rdy_uart = 1'b0;
  logic        s_clr_uart;
  logic [15:0] s_cmd;
  logic        s_cmd_rdy;
  logic        s_clr = 1'b0;
  logic        s_send = 1'b0;
  logic [7:0]  s_resp;
  logic        s_active;
  logic        s_err;

  logic [7:0] mem   [32];
  logic [7:0] s_mem [32];

  int errors = 0;
  int checks = 0;
  int resp_count;

  always #5 clk = ~clk;

  // Synchronous move memories.
  always @(posedge clk) move   <= mem[mv_indx];
  always @(posedge clk) s_move <= s_mem[s_mv_indx];

  tour_cmd_seq #(.NUM_MOVES(4), .MV_AW(5)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .mv_indx(mv_indx),
    .move(move), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .tour_active(tour_active), .tour_err(tour_err)
  );

  tour_cmd_seq #(.NUM_MOVES(1), .MV_AW(5)) dut1 (
    .clk(clk), .rst(rst), .start_tour(s_start), .mv_indx(s_mv_indx),
    .move(s_move), .cmd_UART(s_cmd_uart), .cmd_rdy_UART(s_rdy_uart),
    .clr_cmd_rdy_UART(s_clr_uart), .cmd(s_cmd), .cmd_rdy(s_cmd_rdy),
    .clr_cmd_rdy(s_clr), .send_resp(s_send), .resp(s_resp),
    .tour_active(s_active), .tour_err(s_err)
  );

  // Reference model: knight displacement per one-hot bit (north/east positive).
  function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horizontal,
                                          input bit final_leg);
    int dy[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int k = 0;
    int d;
    logic [7:0] hd;
    logic [3:0] sq;
    for (int i = 0; i < 8; i++) if (mv[i]) k = i;
    d  = horizontal ? dx[k] : dy[k];
    if (horizontal) hd = (d > 0) ? 8'hBF : 8'h3F;
    else            hd = (d > 0) ? 8'h00 : 8'h7F;
    sq = 4'((d < 0) ? -d : d);
    return {(final_leg ? 4'h5 : 4'h4), hd, sq};
  endfunction

  // Act as cmd_proc for one leg on the main instance.
  task automatic do_leg(input logic [15:0] exp_cmd, input logic [7:0] exp_resp,
                        input int exp_idx, input bit early, input int exp_wait,
                        input bit poke, input bit rnd);
    int n = 0;
    int w;
    while (cmd_rdy !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL leg_timeout cmd_rdy=%b required 1", cmd_rdy); return;
    end
    if (exp_wait >= 0) begin
      checks++;
      if (n != exp_wait) begin
        errors++; $display("FAIL leg_latency cycles=%0d required %0d", n, exp_wait);
      end
    end
    checks++;
    if (cmd !== exp_cmd) begin
      errors++; $display("FAIL leg_cmd cmd=%h required %h", cmd, exp_cmd);
    end
    checks++;
    if (mv_indx !== 5'(exp_idx)) begin
      errors++; $display("FAIL leg_index mv_indx=%0d required %0d", mv_indx, exp_idx);
    end
    w = rnd ? $urandom_range(0, 2) : 0;
    repeat (w) begin
      @(posedge clk); #1;
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
        errors++; $display("FAIL leg_hold cmd=%h rdy=%b required %h 1", cmd, cmd_rdy, exp_cmd);
      end
    end
    clr_cmd_rdy = 1'b1;
    send_resp   = early;
    #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b0) begin
      errors++; $display("FAIL leg_uart_clr clr_cmd_rdy_UART=%b required 0", clr_cmd_rdy_UART);
    end
    if (early) begin
      checks++;
      if (resp !== exp_resp) begin
        errors++; $display("FAIL early_resp resp=%h required %h", resp, exp_resp);
      end
    end
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    if (early) resp_count++;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL leg_drop cmd_rdy=%b required 0", cmd_rdy);
    end
    if (!early) begin
      w = poke ? 1 : (rnd ? $urandom_range(0, 3) : 0);
      repeat (w) begin
        start_tour = poke;
        @(posedge clk); #1;
        start_tour = 1'b0;
      end
      send_resp = 1'b1;
      #1;
      checks++;
      if (resp !== exp_resp) begin
        errors++; $display("FAIL leg_resp resp=%h required %h", resp, exp_resp);
      end
      @(posedge clk); #1;
      send_resp = 1'b0;
      resp_count++;
    end
  endtask

  task automatic run_tour(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                          input logic [7:0] m3, input bit rnd, input bit contend);
    logic [7:0] mv[4];
    bit early, prev_early;
    mv = '{m0, m1, m2, m3};
    for (int i = 0; i < 4; i++) mem[i] = mv[i];
    resp_count = 0;
    start_tour = 1'b1;
    @(posedge clk); #1;
    start_tour = 1'b0;
    checks++;
    if (tour_active !== 1'b1 || tour_err !== 1'b0) begin
      errors++; $display("FAIL tour_start active=%b err=%b required 1 0", tour_active, tour_err);
    end
    if (contend) begin
      cmd_UART     = 16'hABCD;
      cmd_rdy_UART = 1'b1;
    end
    prev_early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      early = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      do_leg(leg_cmd(mv[i], 1'b0, 1'b0), 8'h5A, i, early,
             (i == 0) ? 2 : (prev_early ? 3 : 2), contend && (i == 1) && !early, rnd);
      prev_early = early;
      early = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      do_leg(leg_cmd(mv[i], 1'b1, i == 3), (i == 3) ? 8'hA5 : 8'h5A, i, early,
             prev_early ? 1 : 0, 1'b0, rnd);
      prev_early = early;
    end
    @(posedge clk); #1;
    checks++;
    if (tour_active !== 1'b0 || mv_indx !== 5'd3 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL tour_end active=%b mv_indx=%0d resp=%h required 0 3 a5",
               tour_active, mv_indx, resp);
    end
    checks++;
    if (resp_count != 8) begin
      errors++; $display("FAIL tour_resp_count count=%0d required 8", resp_count);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tour_active !== 1'b0 || mv_indx !== 5'd0 || cmd_rdy !== 1'b0 ||
        clr_cmd_rdy_UART !== 1'b0 || resp !== 8'hA5 || tour_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values active=%b idx=%0d rdy=%b clr=%b resp=%h err=%b required 0 0 0 0 a5 0",
               tour_active, mv_indx, cmd_rdy, clr_cmd_rdy_UART, resp, tour_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (tour_active !== 1'b0 || s_active !== 1'b0 || s_resp !== 8'hA5) begin
      errors++; $display("FAIL reset_release active=%b s_active=%b s_resp=%h required 0 0 a5",
                         tour_active, s_active, s_resp);
    end
  endtask

  task automatic test_pass_through();
    cmd_UART = 16'h47F2; cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (cmd !== 16'h47F2 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL pass_cmd cmd=%h rdy=%b required 47f2 1", cmd, cmd_rdy);
    end
    clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b1) begin
      errors++; $display("FAIL pass_clr clr_cmd_rdy_UART=%b required 1", clr_cmd_rdy_UART);
    end
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0 || tour_active !== 1'b0) begin
      errors++; $display("FAIL pass_release clr=%b rdy=%b active=%b required 0 0 0",
                         clr_cmd_rdy_UART, cmd_rdy, tour_active);
    end
  endtask

  task automatic test_single_move();
    int n = 0;
    s_mem[0] = 8'h20;
    s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
    for (int leg = 0; leg < 2; leg++) begin
      n = 0;
      while (s_cmd_rdy !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (s_cmd !== leg_cmd(8'h20, leg == 1, leg == 1) || s_cmd_rdy !== 1'b1) begin
        errors++; $display("FAIL single_cmd leg=%0d cmd=%h rdy=%b required %h 1",
                           leg, s_cmd, s_cmd_rdy, leg_cmd(8'h20, leg == 1, leg == 1));
      end
      s_clr = 1'b1; @(posedge clk); #1; s_clr = 1'b0;
      s_send = 1'b1; #1;
      checks++;
      if (s_resp !== ((leg == 1) ? 8'hA5 : 8'h5A)) begin
        errors++; $display("FAIL single_resp leg=%0d resp=%h required %h",
                           leg, s_resp, (leg == 1) ? 8'hA5 : 8'h5A);
      end
      @(posedge clk); #1; s_send = 1'b0;
    end
    checks++;
    if (s_active !== 1'b0 || s_mv_indx !== 5'd0 || s_err !== 1'b0) begin
      errors++; $display("FAIL single_end active=%b idx=%0d err=%b required 0 0 0",
                         s_active, s_mv_indx, s_err);
    end
  endtask

  task automatic test_illegal(input logic [7:0] bad_first);
    int seen = 0;
    mem[0] = 8'h01; mem[1] = 8'h03;
    if (bad_first != 8'hFF) mem[0] = bad_first;
    resp_count = 0;
    start_tour = 1'b1; @(posedge clk); #1; start_tour = 1'b0;
    if (bad_first == 8'hFF) begin
      do_leg(leg_cmd(8'h01, 1'b0, 1'b0), 8'h5A, 0, 1'b0, 2, 1'b0, 1'b0);
      do_leg(leg_cmd(8'h01, 1'b1, 1'b0), 8'h5A, 0, 1'b0, 0, 1'b0, 1'b0);
    end
    repeat (6) begin
      if (cmd_rdy === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || tour_err !== 1'b1 || tour_active !== 1'b0) begin
      errors++; $display("FAIL illegal_move rdy_seen=%0d err=%b active=%b required 0 1 0",
                         seen, tour_err, tour_active);
    end
    cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (cmd !== cmd_UART || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL illegal_pass cmd=%h rdy=%b required %h 1", cmd, cmd_rdy, cmd_UART);
    end
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_contention();
    run_tour(8'h04, 8'h08, 8'h40, 8'h80, 1'b0, 1'b1);
    #1;
    checks++;
    if (cmd !== 16'hABCD || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL contention_fwd cmd=%h rdy=%b required abcd 1", cmd, cmd_rdy);
    end
    clr_cmd_rdy = 1'b1; #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b1) begin
      errors++; $display("FAIL contention_clr clr_cmd_rdy_UART=%b required 1", clr_cmd_rdy_UART);
    end
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_reset_mid_tour();
    int n = 0;
    int seen = 0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h02;
    start_tour = 1'b1; @(posedge clk); #1; start_tour = 1'b0;
    do_leg(leg_cmd(8'h02, 1'b0, 1'b0), 8'h5A, 0, 1'b0, 2, 1'b0, 1'b0);
    do_leg(leg_cmd(8'h02, 1'b1, 1'b0), 8'h5A, 0, 1'b0, 0, 1'b0, 1'b0);
    while (cmd_rdy !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    clr_cmd_rdy = 1'b1; @(posedge clk); #1; clr_cmd_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tour_active !== 1'b0 || mv_indx !== 5'd0 || cmd_rdy !== 1'b0 ||
        clr_cmd_rdy_UART !== 1'b0 || resp !== 8'hA5 || tour_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid active=%b idx=%0d rdy=%b clr=%b resp=%h err=%b required 0 0 0 0 a5 0",
               tour_active, mv_indx, cmd_rdy, clr_cmd_rdy_UART, resp, tour_err);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (6) begin
      if (cmd_rdy === 1'b1 || tour_active === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_after activity_cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = 8'h01; s_mem[i] = 8'h01; end
    test_reset();
    test_pass_through();
    test_single_move();
    run_tour(8'h20, 8'h01, 8'h02, 8'h10, 1'b0, 1'b0);
    test_illegal(8'hFF);
    run_tour(8'h80, 8'h40, 8'h20, 8'h08, 1'b0, 1'b0);
    test_illegal(8'h00);
    test_contention();
    for (int t = 0; t < 6; t++)
      run_tour(8'(1 << $urandom_range(0, 7)), 8'(1 << $urandom_range(0, 7)),
               8'(1 << $urandom_range(0, 7)), 8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
    test_reset_mid_tour();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
